// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// FSM state encoding and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_e;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a 32-bit memory word
// for RV32I loads.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rd_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd_i[{off_i, 3'b000} +: 8];
  assign half_sel = rd_i[{off_i[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    data_o = rd_i;
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit in front of a registered-read memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of
// silently aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic                     REQ_WE,
  input  logic [2:0]               REQ_FUNCT3,
  input  logic [ADDRESS_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]    REQ_WDATA,
  output logic                     RSP_VALID,
  output logic [DATA_WIDTH-1:0]    RSP_RDATA,
  output logic                     RSP_FAULT,
  output logic [ADDRESS_WIDTH-1:0] MEM_A,
  output logic                     MEM_WE,
  output logic [3:0]               MEM_BE,
  output logic [DATA_WIDTH-1:0]    MEM_WD,
  input  logic [DATA_WIDTH-1:0]    MEM_RD
);

  lsu_state_e                state_q;
  logic                      ready_q;
  logic                      we_q;
  logic [2:0]                funct3_q;
  logic [1:0]                off_q;
  logic                      rsp_valid_q;
  logic                      rsp_fault_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic [ADDRESS_WIDTH-1:0]  mem_a_q;
  logic                      mem_we_q;
  logic [3:0]                mem_be_q;
  logic [DATA_WIDTH-1:0]     mem_wd_q;

  logic [1:0]                off_d;
  logic [3:0]                be_d;
  logic [DATA_WIDTH-1:0]     wd_d;
  logic                      misaligned_d;
  logic                      fault_d;
  logic [DATA_WIDTH-1:0]     ext_data;

  // Halfwords only look at addr[1] and words ignore the offset, so the lanes
  // never spill into the neighbouring word.
  always_comb begin
    off_d = REQ_ADDR[1:0];
    be_d  = 4'b1111;
    wd_d  = REQ_WDATA;
    case (REQ_FUNCT3[1:0])
      2'b00: begin
        be_d = 4'b0001 << off_d;
        wd_d = {4{REQ_WDATA[7:0]}};
      end
      2'b01: begin
        off_d = {REQ_ADDR[1], 1'b0};
        be_d  = 4'b0011 << off_d;
        wd_d  = {2{REQ_WDATA[15:0]}};
      end
      default: off_d = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned_d = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                        ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
`else
  assign misaligned_d = 1'b0;
`endif

  assign fault_d = !funct3_legal(REQ_WE, REQ_FUNCT3) || misaligned_d;

  load_extend u_load_extend (
    .rd_i     (MEM_RD),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      funct3_q    <= F3_B;
      off_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_a_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_wd_q    <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (REQ_VALID) begin
            we_q     <= REQ_WE;
            funct3_q <= REQ_FUNCT3;
            off_q    <= off_d;
            ready_q  <= 1'b0;
            if (fault_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q  <= ISSUE;
              mem_a_q  <= {REQ_ADDR[ADDRESS_WIDTH-1:2], 2'b00};
              mem_be_q <= be_d;
              mem_we_q <= REQ_WE;
              if (REQ_WE) mem_wd_q <= wd_d;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= 1'b0;
          rsp_rdata_q <= ext_data;
        end
        RESP: begin
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          rsp_fault_q <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign REQ_READY = ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_FAULT = rsp_fault_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign MEM_A     = mem_a_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_BE    = mem_be_q;
  assign MEM_WD    = mem_wd_q;

endmodule
